// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch buffer between the PC unit and decode.
//   Takes fetch PCs (pc_valid/pc_ready) and issues in-order instruction memory reads
//   (mem_req/mem_gnt, then mem_rvalid beats in request order). Up to DEPTH fetches are
//   held in flight or buffered. Each 32-bit instruction goes to decode with its PC over
//   inst_valid/inst_ready.
//   flush drops every buffered and in-flight fetch. Beats still owed for squashed requests
//   are counted in drop_q and discarded when they arrive.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pc_valid, pc, pc_ready     fetch PC handshake
//   flush                      redirect
//   mem_req, mem_addr, mem_gnt read request (8-byte aligned address)
//   mem_rvalid, mem_rdata      read data beat (64 bits)
//   inst_valid, inst, inst_pc  instruction to decode
//   inst_ready                 decode accepts the instruction
module ifu_fetch #(
  parameter int unsigned CPU_WIDTH  = 64,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_valid,
  input  logic [CPU_WIDTH-1:0]  pc,
  output logic                  pc_ready,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [CPU_WIDTH-1:0]  mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [63:0]           mem_rdata,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0]  inst_pc,
  input  logic                  inst_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  logic [CPU_WIDTH-1:0]  slot_pc_q   [DEPTH];
  logic [INST_WIDTH-1:0] slot_data_q [DEPTH];
  logic [DEPTH-1:0]      slot_full_q;

  // fill_q points at the oldest allocated slot still waiting for its beat.
  ptr_t head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  // pend_q counts allocated slots not yet filled; drop_q counts beats owed to squashed reads.
  cnt_t count_q, count_d, pend_q, pend_d, drop_q, drop_d;

  logic [CntW:0] used;
  logic          credit, accept, pop, fill, discard;
  logic [31:0]   beat_word;

  always_comb begin
    used       = {1'b0, count_q} + {1'b0, drop_q};
    credit     = (used < (CntW + 1)'(DEPTH)) && !flush;
    mem_req    = pc_valid && credit;
    mem_addr   = {pc[CPU_WIDTH-1:3], 3'b000};
    pc_ready   = mem_gnt && credit;
    accept     = pc_valid && pc_ready;
    inst_valid = slot_full_q[head_q] && !flush;
    inst       = slot_data_q[head_q];
    inst_pc    = slot_pc_q[head_q];
    pop        = inst_valid && inst_ready;
    discard    = mem_rvalid && (drop_q != '0);
    // A beat with nothing pending and nothing to drop is a protocol error and is ignored.
    fill       = mem_rvalid && (drop_q == '0) && (pend_q != '0);
    beat_word  = slot_pc_q[fill_q][2] ? mem_rdata[63:32] : mem_rdata[31:0];
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      pend_d  = '0;
      // Every unfilled slot becomes an owed beat; a beat arriving now settles one of them.
      drop_d  = drop_q + pend_q
              - cnt_t'(mem_rvalid && ((drop_q != '0) || (pend_q != '0)));
    end else begin
      if (accept) tail_d = ptr_inc(tail_q);
      if (fill)   fill_d = ptr_inc(fill_q);
      if (pop)    head_d = ptr_inc(head_q);
      count_d = count_q + cnt_t'(accept) - cnt_t'(pop);
      pend_d  = pend_q + cnt_t'(accept) - cnt_t'(fill);
      drop_d  = drop_q - cnt_t'(discard);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  // accept, fill and pop always touch distinct slots, so their writes never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]   <= '0;
        slot_data_q[i] <= '0;
      end
    end else if (flush) begin
      slot_full_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]   <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        slot_pc_q[tail_q]   <= pc;
        slot_full_q[tail_q] <= 1'b0;
      end
      if (fill) begin
        slot_data_q[fill_q] <= INST_WIDTH'(beat_word);
        slot_full_q[fill_q] <= 1'b1;
      end
      if (pop) slot_full_q[head_q] <= 1'b0;
    end
  end

endmodule
